// File: rtl/alu_collect_pkg.sv
// Shared width helpers, default parameters and the FIFO entry layout for the
// multi-channel ALU result collector.
package alu_collect_pkg;

    localparam int unsigned DefNumCh        = 4;
    localparam int unsigned DefResultWidth  = 16;
    localparam int unsigned DefFifoDepth    = 8;
    localparam int unsigned DefDropCntWidth = 8;

    // Channel index width; a single channel still needs a one-bit tag.
    function automatic int unsigned ch_width(input int unsigned num_ch);
        return (num_ch <= 1) ? 1 : $clog2(num_ch);
    endfunction

    // Occupancy width able to represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`ifndef ALU_COLLECT_ENTRY_T
`define ALU_COLLECT_ENTRY_T(CW, RW) struct packed { logic [(CW)-1:0] ch; logic [(RW)-1:0] res; }
`endif

// File: rtl/alu_collect_fifo.sv
// Synchronous FIFO with registered occupancy; head reads as zero when empty.
module alu_collect_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_push = push && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: head is gated by occupancy.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/alu_result_collector.sv
// Captures per-channel ALU done/result strobes, arbitrates them round-robin into
// a shared FIFO and counts results lost while a channel's hold register is busy.
module alu_result_collector
    import alu_collect_pkg::*;
#(
    parameter int unsigned NUM_CH         = DefNumCh,
    parameter int unsigned RESULT_WIDTH   = DefResultWidth,
    parameter int unsigned FIFO_DEPTH     = DefFifoDepth,
    parameter int unsigned DROP_CNT_WIDTH = DefDropCntWidth,
    localparam int unsigned CH_W          = ch_width(NUM_CH),
    localparam int unsigned CNT_W         = cnt_width(FIFO_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CH-1:0]              done,
    input  logic [NUM_CH*RESULT_WIDTH-1:0] result,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RESULT_WIDTH-1:0]        out_result,
    output logic [CH_W-1:0]                out_ch,
    output logic [CNT_W-1:0]               fifo_count,
    output logic [NUM_CH-1:0]              drop_flag,
    output logic [DROP_CNT_WIDTH-1:0]      drop_cnt,
    input  logic                           clr_drop
);

    typedef `ALU_COLLECT_ENTRY_T(CH_W, RESULT_WIDTH) entry_t;

    // Wide enough for a saturated count plus every channel dropping at once.
    localparam int unsigned SumW = DROP_CNT_WIDTH + CH_W + 1;

    logic [NUM_CH-1:0]         pend_q, pend_d;
    logic [RESULT_WIDTH-1:0]   hold_q [NUM_CH];
    logic [RESULT_WIDTH-1:0]   hold_d [NUM_CH];
    logic [CH_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0]         drop_flag_q, drop_flag_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                      grant_valid;
    logic [CH_W-1:0]           grant_idx;
    logic [NUM_CH-1:0]         grant_oh;
    logic [CH_W:0]             arb_idx;
    logic [NUM_CH-1:0]         drop_vec;
    logic [SumW-1:0]           drop_sum;
    logic                      pop;
    entry_t                    push_entry;
    entry_t                    head_entry;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        arb_idx     = '0;
        if (fifo_count < CNT_W'(FIFO_DEPTH)) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                arb_idx = {1'b0, rr_ptr_q} + (CH_W + 1)'(k);
                if (arb_idx >= (CH_W + 1)'(NUM_CH)) begin
                    arb_idx = arb_idx - (CH_W + 1)'(NUM_CH);
                end
                if (!grant_valid && pend_q[arb_idx[CH_W-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = arb_idx[CH_W-1:0];
                end
            end
        end
        if (grant_valid) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_valid) begin
            rr_ptr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // A granted channel frees its hold register this cycle, so a same-cycle
    // strobe reloads it instead of dropping.
    always_comb begin
        pend_d   = pend_q;
        hold_d   = hold_q;
        drop_vec = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_oh[i]) begin
                pend_d[i] = 1'b0;
            end
            if (done[i]) begin
                if (pend_q[i] && !grant_oh[i]) begin
                    drop_vec[i] = 1'b1;
                end else begin
                    hold_d[i] = result[i*RESULT_WIDTH +: RESULT_WIDTH];
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    // Clear applies before this cycle's drops are accounted.
    always_comb begin
        drop_sum = clr_drop ? '0 : SumW'(drop_cnt_q);
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            drop_sum = drop_sum + SumW'(drop_vec[i]);
        end
        drop_cnt_d  = (drop_sum > SumW'({DROP_CNT_WIDTH{1'b1}})) ? '1
                                                                : drop_sum[DROP_CNT_WIDTH-1:0];
        drop_flag_d = (clr_drop ? '0 : drop_flag_q) | drop_vec;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_q      <= '0;
            hold_q      <= '{default: '0};
            rr_ptr_q    <= '0;
            drop_flag_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            rr_ptr_q    <= rr_ptr_d;
            drop_flag_q <= drop_flag_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_comb begin
        push_entry     = '0;
        push_entry.ch  = grant_idx;
        push_entry.res = hold_q[grant_idx];
    end

    assign pop = out_valid && out_ready;

    alu_collect_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant_valid),
        .push_data (push_entry),
        .pop       (pop),
        .count     (fifo_count),
        .head      (head_entry)
    );

    assign out_valid  = (fifo_count != '0);
    assign out_result = head_entry.res;
    assign out_ch     = head_entry.ch;
    assign drop_flag  = drop_flag_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_alu_result_collector.sv
// Self-checking bench: reference model feeds a scoreboard queue, a negedge
// monitor compares every DUT output against it; directed scenarios plus random traffic.
module tb_alu_result_collector;

    localparam int N  = 4;
    localparam int RW = 16;
    localparam int D  = 8;
    localparam int DMAX = 255;

    logic            clk;
    logic            rst;
    logic [N-1:0]    done;
    logic [N*RW-1:0] result;
    logic            out_valid;
    logic            out_ready;
    logic [RW-1:0]   out_result;
    logic [1:0]      out_ch;
    logic [3:0]      fifo_count;
    logic [N-1:0]    drop_flag;
    logic [7:0]      drop_cnt;
    logic            clr_drop;

    alu_result_collector dut (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .result     (result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_ch     (out_ch),
        .fifo_count (fifo_count),
        .drop_flag  (drop_flag),
        .drop_cnt   (drop_cnt),
        .clr_drop   (clr_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int res;
    } exp_t;

    exp_t         exp_q[$];
    int           m_pend[N];
    int           m_hold[N];
    int           m_rr;
    int           m_count;
    int           m_dcnt;
    logic [N-1:0] m_flag;
    int           n_vec;
    int           n_fail;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one spec step per rising edge, using inputs held since the last edge.
    always @(posedge clk) begin : model
        int g;
        int nd;
        int idx;
        bit pop;
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                m_pend[i] = 0;
                m_hold[i] = 0;
            end
            m_rr    = 0;
            m_count = 0;
            m_dcnt  = 0;
            m_flag  = '0;
            exp_q.delete();
        end else begin
            pop = (m_count > 0) && out_ready;
            g   = -1;
            if (m_count < D) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_rr + k) % N;
                    if (g < 0 && m_pend[idx] != 0) g = idx;
                end
            end
            if (clr_drop) begin
                m_dcnt = 0;
                m_flag = '0;
            end
            if (g >= 0) begin
                exp_q.push_back('{ch: g, res: m_hold[g]});
                m_pend[g] = 0;
                m_rr      = (g + 1) % N;
            end
            nd = 0;
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    if (m_pend[i] != 0) begin
                        nd++;
                        m_flag[i] = 1'b1;
                    end else begin
                        m_hold[i] = int'(result[i*RW +: RW]);
                        m_pend[i] = 1;
                    end
                end
            end
            m_dcnt  = (m_dcnt + nd > DMAX) ? DMAX : m_dcnt + nd;
            m_count = m_count + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    always @(negedge clk) begin : monitor
        check("out_valid", int'(out_valid), (m_count != 0) ? 1 : 0);
        check("fifo_count", int'(fifo_count), m_count);
        check("drop_cnt", int'(drop_cnt), m_dcnt);
        check("drop_flag", int'(drop_flag), int'(m_flag));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL head: out_valid=1 but no result expected at %0t", $time);
            end else begin
                check("out_ch", int'(out_ch), exp_q[0].ch);
                check("out_result", int'(out_result), exp_q[0].res);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_res(input int ch, input int v);
        result[ch*RW +: RW] = RW'(v);
    endtask

    initial begin
        n_vec     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        done      = '0;
        result    = '0;
        out_ready = 1'b0;
        clr_drop  = 1'b0;
        step();
        step();
        check("rst out_valid", int'(out_valid), 0);
        check("rst out_result", int'(out_result), 0);
        check("rst out_ch", int'(out_ch), 0);
        check("rst fifo_count", int'(fifo_count), 0);
        check("rst drop_flag", int'(drop_flag), 0);
        check("rst drop_cnt", int'(drop_cnt), 0);
        rst = 1'b1;

        // Single result, two-cycle latency.
        out_ready = 1'b1;
        done      = 4'b0100;
        set_res(2, 16'hBEEF);
        step();
        done = '0;
        check("lat t+1 valid", int'(out_valid), 0);
        step();
        check("lat t+2 valid", int'(out_valid), 1);
        check("lat result", int'(out_result), 16'hBEEF);
        check("lat ch", int'(out_ch), 2);
        step();
        check("lat t+3 count", int'(fifo_count), 0);

        // Simultaneous bursts drain in round-robin channel order.
        rst = 1'b0;
        step();
        rst = 1'b1;
        for (int b = 0; b < 2; b++) begin
            done = 4'b1111;
            for (int c = 0; c < N; c++) set_res(c, c + 1);
            step();
            done = '0;
            for (int k = 0; k < N; k++) begin
                step();
                check("rr ch", int'(out_ch), k);
                check("rr result", int'(out_result), k + 1);
            end
        end
        step();

        // Back-pressure on a single channel.
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            done = 4'b0001;
            set_res(0, 100 + k);
            step();
            if (k == 8) check("bp no early drop", int'(drop_cnt), 0);
        end
        done = '0;
        check("bp count", int'(fifo_count), D);
        check("bp head hold", int'(out_result), 100);
        check("bp flag", int'(drop_flag), 4'b0001);
        check("bp drop_cnt", int'(drop_cnt), 1);
        out_ready = 1'b1;
        for (int j = 0; j < 9; j++) begin
            check("bp drain", int'(out_result), 100 + j);
            step();
        end
        check("bp drained", int'(fifo_count), 0);

        // Drop counter saturation, then clear coinciding with one drop.
        out_ready = 1'b0;
        for (int k = 0; k < 80; k++) begin
            done = 4'b1111;
            for (int c = 0; c < N; c++) set_res(c, int'($urandom_range(0, 65535)));
            step();
        end
        check("sat drop_cnt", int'(drop_cnt), DMAX);
        clr_drop = 1'b1;
        done     = 4'b0010;
        step();
        clr_drop = 1'b0;
        done     = '0;
        check("clr drop_cnt", int'(drop_cnt), 1);
        check("clr flag", int'(drop_flag), 4'b0010);

        // Reset with entries queued and channel 1 pending.
        out_ready = 1'b1;
        repeat (20) step();
        out_ready = 1'b0;
        done      = 4'b1101;
        for (int c = 0; c < N; c++) set_res(c, 16'h0A00 + c);
        step();
        done = '0;
        repeat (3) step();
        done = 4'b0010;
        set_res(1, 16'h0A11);
        step();
        done = '0;
        check("pre-rst count", int'(fifo_count), 3);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("mid-rst valid", int'(out_valid), 0);
        check("mid-rst count", int'(fifo_count), 0);
        check("mid-rst drop_cnt", int'(drop_cnt), 0);
        check("mid-rst flag", int'(drop_flag), 0);
        out_ready = 1'b1;
        done      = 4'b0010;
        set_res(1, 16'h0777);
        step();
        done = '0;
        check("post-rst t+1 valid", int'(out_valid), 0);
        step();
        check("post-rst valid", int'(out_valid), 1);
        check("post-rst ch", int'(out_ch), 1);
        check("post-rst result", int'(out_result), 16'h0777);
        step();

        // Strobe in the same cycle the pending channel is granted.
        done = 4'b1000;
        set_res(3, 16'h1234);
        step();
        set_res(3, 16'h0055);
        step();
        done = '0;
        check("reload first", int'(out_result), 16'h1234);
        step();
        check("reload second", int'(out_result), 16'h0055);
        check("reload ch", int'(out_ch), 3);
        check("reload no drop", int'(drop_cnt), 0);
        step();
        check("reload drained", int'(fifo_count), 0);

        // Random traffic, alternating light and heavy back-pressure.
        for (int k = 0; k < 3000; k++) begin
            done = N'($urandom);
            for (int c = 0; c < N; c++) set_res(c, int'($urandom_range(0, 65535)));
            if ((k / 250) % 2 == 0) out_ready = ($urandom_range(0, 3) != 0);
            else out_ready = ($urandom_range(0, 3) == 0);
            clr_drop = ($urandom_range(0, 31) == 0);
            rst      = ($urandom_range(0, 299) != 0);
            step();
        end
        done      = '0;
        clr_drop  = 1'b0;
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (30) step();
        check("final empty", int'(fifo_count), 0);
        check("scoreboard empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
